bus_interconnect: RTL and testbench

Parametrised successor to simple_bus: a 2-master (ibus, dbus) to NUM_SLAVES-slave interconnect with programmable address map, round-robin arbitration, per-slave execute permission, unmapped-address error and slave timeout. It sits between cpu_core and the RAM/timer/UART slaves. It replaces fixed per-slave port sets with indexed slave vectors, so new peripherals are added by parameter only. One transaction is outstanding at a time.

---
 rtl/bus_interconnect.sv | 250 +++++++++++++++++++++++++
 tb/tb_bus_interconnect.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//
// Two-master (ibus fetch, dbus data) to NUM_SLAVES-slave interconnect.
// One transaction is in flight at a time. Masters are arbitrated
// round-robin in IDLE. The winner's address is decoded against a
// programmable base/mask map, where the lowest slave index wins on overlap.
// Unmapped addresses, and ibus fetches from non-executable slaves, get an
// immediate error response. A slave that never answers is cut off after
// TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ibus_req/addr            fetch request (held until ibus_ready)
//   ibus_rdata/ready/error   fetch response (ready is a one-cycle pulse)
//   dbus_req/we/addr/wdata/wstrb  data request (held until dbus_ready)
//   dbus_rdata/ready/error   data response (ready is a one-cycle pulse)
//   s_req                    one-hot slave select
//   s_we/addr/wdata/wstrb    shared slave request fields (address not rebased)
//   s_rdata                  packed read data, slice i belongs to slave i
//   s_ready                  per-slave completion
// ---------------------------------------------------------------------------
module bus_interconnect #(
    parameter int                        NUM_SLAVES     = 3,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = {32'h10000000, 32'h02000000, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {32'hFFFFFF00, 32'hFF000000, 32'hFFC00000},
    parameter logic [NUM_SLAVES-1:0]     SLAVE_EXEC     = 3'b001,
    parameter int                        TIMEOUT_CYCLES = 256,
    parameter int                        TO_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ibus_req,
    input  logic [31:0]              ibus_addr,
    output logic [31:0]              ibus_rdata,
    output logic                     ibus_ready,
    output logic                     ibus_error,
    input  logic                     dbus_req,
    input  logic                     dbus_we,
    input  logic [31:0]              dbus_addr,
    input  logic [31:0]              dbus_wdata,
    input  logic [3:0]               dbus_wstrb,
    output logic [31:0]              dbus_rdata,
    output logic                     dbus_ready,
    output logic                     dbus_error,
    output logic [NUM_SLAVES-1:0]    s_req,
    output logic                     s_we,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Count value at which the access is abandoned; only used when the
    // timeout is enabled.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                 state_reg, state_next;
    logic                   grant_reg, grant_next;           // 1 = dbus owns the transaction
    logic                   last_grant_reg, last_grant_next; // 1 = dbus won last
    logic [SEL_W-1:0]       sel_reg, sel_next;
    logic [NUM_SLAVES-1:0]  s_req_reg, s_req_next;
    logic                   s_we_reg, s_we_next;
    logic [31:0]            s_addr_reg, s_addr_next;
    logic [31:0]            s_wdata_reg, s_wdata_next;
    logic [3:0]             s_wstrb_reg, s_wstrb_next;
    logic [TO_WIDTH-1:0]    to_cnt_reg, to_cnt_next;
    logic [31:0]            ibus_rdata_reg, ibus_rdata_next;
    logic                   ibus_ready_reg, ibus_ready_next;
    logic                   ibus_error_reg, ibus_error_next;
    logic [31:0]            dbus_rdata_reg, dbus_rdata_next;
    logic                   dbus_ready_reg, dbus_ready_next;
    logic                   dbus_error_reg, dbus_error_next;

    // Arbitration: a lone requester wins; on a tie the master that did
    // not win last time takes the grant.
    logic        win_d;
    logic [31:0] win_addr;
    assign win_d    = dbus_req && (!ibus_req || !last_grant_reg);
    assign win_addr = win_d ? dbus_addr : ibus_addr;

    // Address decode of the arbitration winner.
    logic [NUM_SLAVES-1:0] hit;
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
            assign hit[gi] = ((win_addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32]);
        end
    endgenerate

    logic             any_hit;
    logic [SEL_W-1:0] hit_idx;
    always_comb begin
        any_hit = |hit;
        hit_idx = '0;
        // Scan downwards so the lowest matching index is the one kept.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Response mux for the currently selected slave.
    logic        sel_ready;
    logic [31:0] sel_rdata;
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_reg == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        sel_next        = sel_reg;
        s_req_next      = s_req_reg;
        s_we_next       = s_we_reg;
        s_addr_next     = s_addr_reg;
        s_wdata_next    = s_wdata_reg;
        s_wstrb_next    = s_wstrb_reg;
        to_cnt_next     = to_cnt_reg;
        // Response outputs are only non-zero during the single RESP cycle.
        ibus_rdata_next = '0;
        ibus_ready_next = 1'b0;
        ibus_error_next = 1'b0;
        dbus_rdata_next = '0;
        dbus_ready_next = 1'b0;
        dbus_error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ibus_req || dbus_req) begin
                    grant_next      = win_d;
                    last_grant_next = win_d;
                    if (!any_hit || (!win_d && !SLAVE_EXEC[hit_idx])) begin
                        state_next      = RESP;
                        ibus_ready_next = !win_d;
                        ibus_error_next = !win_d;
                        dbus_ready_next = win_d;
                        dbus_error_next = win_d;
                    end else begin
                        state_next   = ACCESS;
                        sel_next     = hit_idx;
                        s_req_next   = NUM_SLAVES'(1) << hit_idx;
                        s_we_next    = win_d && dbus_we;
                        s_addr_next  = win_addr;
                        s_wdata_next = win_d ? dbus_wdata : 32'h0;
                        s_wstrb_next = win_d ? dbus_wstrb : 4'h0;
                        to_cnt_next  = '0;
                    end
                end
            end

            ACCESS: begin
                // A completion in the expiry cycle takes precedence.
                if (sel_ready) begin
                    state_next      = RESP;
                    s_req_next      = '0;
                    ibus_ready_next = !grant_reg;
                    dbus_ready_next = grant_reg;
                    ibus_rdata_next = (!grant_reg) ? sel_rdata : 32'h0;
                    dbus_rdata_next = (grant_reg && !s_we_reg) ? sel_rdata : 32'h0;
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_LAST)) begin
                    state_next      = RESP;
                    s_req_next      = '0;
                    ibus_ready_next = !grant_reg;
                    ibus_error_next = !grant_reg;
                    dbus_ready_next = grant_reg;
                    dbus_error_next = grant_reg;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                s_req_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
            sel_reg        <= '0;
            s_req_reg      <= '0;
            s_we_reg       <= 1'b0;
            s_addr_reg     <= '0;
            s_wdata_reg    <= '0;
            s_wstrb_reg    <= '0;
            to_cnt_reg     <= '0;
            ibus_rdata_reg <= '0;
            ibus_ready_reg <= 1'b0;
            ibus_error_reg <= 1'b0;
            dbus_rdata_reg <= '0;
            dbus_ready_reg <= 1'b0;
            dbus_error_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            sel_reg        <= sel_next;
            s_req_reg      <= s_req_next;
            s_we_reg       <= s_we_next;
            s_addr_reg     <= s_addr_next;
            s_wdata_reg    <= s_wdata_next;
            s_wstrb_reg    <= s_wstrb_next;
            to_cnt_reg     <= to_cnt_next;
            ibus_rdata_reg <= ibus_rdata_next;
            ibus_ready_reg <= ibus_ready_next;
            ibus_error_reg <= ibus_error_next;
            dbus_rdata_reg <= dbus_rdata_next;
            dbus_ready_reg <= dbus_ready_next;
            dbus_error_reg <= dbus_error_next;
        end
    end

    assign s_req      = s_req_reg;
    assign s_we       = s_we_reg;
    assign s_addr     = s_addr_reg;
    assign s_wdata    = s_wdata_reg;
    assign s_wstrb    = s_wstrb_reg;
    assign ibus_rdata = ibus_rdata_reg;
    assign ibus_ready = ibus_ready_reg;
    assign ibus_error = ibus_error_reg;
    assign dbus_rdata = dbus_rdata_reg;
    assign dbus_ready = dbus_ready_reg;
    assign dbus_error = dbus_error_reg;

endmodule

// File: tb/tb_bus_interconnect.sv
// ---------------------------------------------------------------------------
// tb_bus_interconnect
//
// Directed bench for bus_interconnect with the default 3-slave map
// (RAM 0x0000_0000/4MB, timer 0x02xx_xxxx, UART 0x1000_00xx) and a 4-cycle
// timeout. Each slave is a small model with programmable wait states, an
// enable (a disabled slave never answers) and a fixed read value.
// Inputs change 1ns after the rising edge; outputs are sampled at that
// point as well, so they show the registered result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_bus_interconnect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ibus_req = 1'b0;
    logic [31:0] ibus_addr = '0;
    logic [31:0] ibus_rdata;
    logic        ibus_ready;
    logic        ibus_error;
    logic        dbus_req = 1'b0;
    logic        dbus_we = 1'b0;
    logic [31:0] dbus_addr = '0;
    logic [31:0] dbus_wdata = '0;
    logic [3:0]  dbus_wstrb = '0;
    logic [31:0] dbus_rdata;
    logic        dbus_ready;
    logic        dbus_error;
    logic [2:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [95:0] s_rdata;
    logic [2:0]  s_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave models.
    logic [2:0]  sl_en = 3'b111;
    int          sl_waits [3] = '{0, 0, 0};
    int          sl_cnt   [3] = '{0, 0, 0};
    logic [31:0] sl_rd    [3] = '{32'hCAFE0000, 32'h00007777, 32'h00000060};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slave
            assign s_ready[gi]          = s_req[gi] && sl_en[gi] && (sl_cnt[gi] >= sl_waits[gi]);
            assign s_rdata[gi*32 +: 32] = sl_rd[gi];
        end
    endgenerate

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            sl_cnt[i] <= (s_req[i] && !s_ready[i]) ? sl_cnt[i] + 1 : 0;
        end
    end

    always #5 clk = ~clk;

    bus_interconnect #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_rdata (ibus_rdata),
        .ibus_ready (ibus_ready),
        .ibus_error (ibus_error),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_wstrb (dbus_wstrb),
        .dbus_rdata (dbus_rdata),
        .dbus_ready (dbus_ready),
        .dbus_error (dbus_error),
        .s_req      (s_req),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .s_ready    (s_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-24s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_s_req",      32'(s_req), 32'h0);
        check("rst_s_addr",     s_addr, 32'h0);
        check("rst_ibus_ready", 32'(ibus_ready), 32'h0);
        check("rst_dbus_ready", 32'(dbus_ready), 32'h0);
        check("rst_dbus_rdata", dbus_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // ---------------- tie after reset: dbus first ----------------
        ibus_req = 1'b1; ibus_addr = 32'h0000_0100;
        dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h0000_0200;
        tick();                                  // cycle 1
        check("tie1_s_req",  32'(s_req), 32'h1);
        check("tie1_s_addr", s_addr, 32'h0000_0200);
        tick();                                  // cycle 2
        check("tie1_dbus_ready", 32'(dbus_ready), 32'h1);
        check("tie1_dbus_rdata", dbus_rdata, 32'hCAFE0000);
        check("tie1_ibus_ready", 32'(ibus_ready), 32'h0);
        dbus_req = 1'b0;
        tick();                                  // IDLE, ibus still held
        tick();
        check("ib_s_addr",  s_addr, 32'h0000_0100);
        check("ib_s_wstrb", 32'(s_wstrb), 32'h0);
        tick();
        check("ib_ibus_ready", 32'(ibus_ready), 32'h1);
        check("ib_ibus_rdata", ibus_rdata, 32'hCAFE0000);
        dbus_req = 1'b1;                         // ibus keeps holding req
        tick();                                  // IDLE: tie again
        tick();
        check("tie2_s_addr", s_addr, 32'h0000_0200);
        tick();
        check("tie2_dbus_ready", 32'(dbus_ready), 32'h1);
        check("tie2_ibus_ready", 32'(ibus_ready), 32'h0);
        ibus_req = 1'b0; dbus_req = 1'b0;
        tick();

        // ---------------- dbus write to RAM, zero wait ----------------
        dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h0000_0010;
        dbus_wdata = 32'hDEADBEEF; dbus_wstrb = 4'hF;
        tick();
        check("wr_s_req",   32'(s_req), 32'h1);
        check("wr_s_addr",  s_addr, 32'h0000_0010);
        check("wr_s_wdata", s_wdata, 32'hDEADBEEF);
        check("wr_s_we",    32'(s_we), 32'h1);
        check("wr_s_wstrb", 32'(s_wstrb), 32'hF);
        check("wr_c1_ready", 32'(dbus_ready), 32'h0);
        tick();
        check("wr_dbus_ready", 32'(dbus_ready), 32'h1);
        check("wr_dbus_error", 32'(dbus_error), 32'h0);
        check("wr_dbus_rdata", dbus_rdata, 32'h0);
        check("wr_c2_s_req",   32'(s_req), 32'h0);
        dbus_req = 1'b0; dbus_we = 1'b0; dbus_wstrb = 4'h0;
        tick();
        check("wr_c3_ready", 32'(dbus_ready), 32'h0);

        // ---------------- ibus fetch from UART: exec fault ----------------
        ibus_req = 1'b1; ibus_addr = 32'h1000_0000;
        tick();
        check("xf_s_req",      32'(s_req), 32'h0);
        check("xf_ibus_ready", 32'(ibus_ready), 32'h1);
        check("xf_ibus_error", 32'(ibus_error), 32'h1);
        check("xf_ibus_rdata", ibus_rdata, 32'h0);
        check("xf_dbus_ready", 32'(dbus_ready), 32'h0);
        ibus_req = 1'b0;
        tick();

        // ---------------- dbus read from UART ----------------
        dbus_req = 1'b1; dbus_addr = 32'h1000_0004;
        tick();
        check("ur_s_req", 32'(s_req), 32'h4);
        tick();
        check("ur_dbus_ready", 32'(dbus_ready), 32'h1);
        check("ur_dbus_rdata", dbus_rdata, 32'h0000_0060);
        check("ur_dbus_error", 32'(dbus_error), 32'h0);
        dbus_req = 1'b0;
        tick();

        // ---------------- unmapped address ----------------
        dbus_req = 1'b1; dbus_addr = 32'h2000_0000;
        tick();
        check("um_s_req",      32'(s_req), 32'h0);
        check("um_dbus_ready", 32'(dbus_ready), 32'h1);
        check("um_dbus_error", 32'(dbus_error), 32'h1);
        dbus_req = 1'b0;
        tick();

        // ---------------- timer decode (outside RAM window) ----------------
        dbus_req = 1'b1; dbus_addr = 32'h0240_0000;
        tick();
        check("tm_s_req", 32'(s_req), 32'h2);
        tick();
        check("tm_dbus_rdata", dbus_rdata, 32'h0000_7777);
        dbus_req = 1'b0;
        tick();

        // ---------------- timer timeout ----------------
        sl_en[1] = 1'b0;
        dbus_req = 1'b1; dbus_addr = 32'h0200_0008;
        tick();                                  // cycle 1
        tick();
        tick();
        tick();                                  // cycle 4
        check("to_c4_s_req", 32'(s_req), 32'h2);
        check("to_c4_ready", 32'(dbus_ready), 32'h0);
        tick();                                  // cycle 5
        check("to_c5_s_req", 32'(s_req), 32'h0);
        check("to_dbus_ready", 32'(dbus_ready), 32'h1);
        check("to_dbus_error", 32'(dbus_error), 32'h1);
        check("to_dbus_rdata", dbus_rdata, 32'h0);
        dbus_req = 1'b0;
        tick();

        // ---------------- ready on the expiry cycle ----------------
        sl_en[1] = 1'b1; sl_waits[1] = 3; sl_rd[1] = 32'h0000_1234;
        dbus_req = 1'b1; dbus_addr = 32'h0200_000C;
        tick();
        tick();
        tick();
        tick();                                  // cycle 4: slave answers
        check("ex_c4_s_ready", 32'(s_ready), 32'h2);
        tick();
        check("ex_dbus_ready", 32'(dbus_ready), 32'h1);
        check("ex_dbus_error", 32'(dbus_error), 32'h0);
        check("ex_dbus_rdata", dbus_rdata, 32'h0000_1234);
        dbus_req = 1'b0;
        tick();

        // ---------------- reset during ACCESS ----------------
        sl_waits[0] = 3;
        dbus_req = 1'b1; dbus_addr = 32'h0000_0040;
        tick();
        check("ra_c1_s_req", 32'(s_req), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("ra_rst_s_req", 32'(s_req), 32'h0);
        dbus_req = 1'b0;
        tick();
        check("ra_rst_ready", 32'(dbus_ready), 32'h0);
        rst = 1'b0;
        tick();
        check("ra_post_ready1", 32'(dbus_ready), 32'h0);
        tick();
        check("ra_post_ready2", 32'(dbus_ready), 32'h0);
        check("ra_post_s_req",  32'(s_req), 32'h0);

        sl_waits[0] = 0; sl_rd[0] = 32'h0BAD_F00D;
        dbus_req = 1'b1; dbus_addr = 32'h0000_0044;
        tick();
        check("rn_s_req",  32'(s_req), 32'h1);
        check("rn_s_addr", s_addr, 32'h0000_0044);
        tick();
        check("rn_dbus_ready", 32'(dbus_ready), 32'h1);
        check("rn_dbus_rdata", dbus_rdata, 32'h0BAD_F00D);
        dbus_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
